// File: rtl/uart_rx_frame_if.sv
// rtl/uart_rx_frame_if.sv - serial line and receive-result bundle of the UART receive framer
//
// Purpose: groups the asynchronous serial input with the per-frame results
// handed to the APB UART register block.
//
// Signals:
//   in_RX_Serial   - asynchronous serial line, idles high
//   out_RX_DV      - one-cycle strobe, a frame has completed
//   out_RX_Byte    - last received byte, held until the next strobe
//   out_Frame_Err  - stop bit sampled low, valid with out_RX_DV and held
//   out_Parity_Err - parity mismatch, valid with out_RX_DV and held
//   out_RX_Busy    - receiver is inside a frame (or waiting out a break)
//
// Modports:
//   master - the framer: samples the line, drives the results
//   slave  - the line driver / result consumer
interface uart_rx_frame_if;
  logic       in_RX_Serial;
  logic       out_RX_DV;
  logic [7:0] out_RX_Byte;
  logic       out_Frame_Err;
  logic       out_Parity_Err;
  logic       out_RX_Busy;

  modport master (
    input  in_RX_Serial,
    output out_RX_DV,
    output out_RX_Byte,
    output out_Frame_Err,
    output out_Parity_Err,
    output out_RX_Busy
  );

  modport slave (
    output in_RX_Serial,
    input  out_RX_DV,
    input  out_RX_Byte,
    input  out_Frame_Err,
    input  out_Parity_Err,
    input  out_RX_Busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receive framer: synchroniser, start check, 8N1 / 8P1 deframing
//
// Purpose: brings the asynchronous serial line into the in_Clk domain,
// validates the start bit at its middle, samples 8 data bits LSB-first,
// an optional parity bit and one stop bit, and delivers each byte with a
// one-cycle data-valid strobe plus framing/parity error flags.
//
// Parameters:
//   CLKS_PER_BIT - in_Clk cycles per bit, >= 2
//   PARITY_EN    - 1 inserts a parity bit between data bit 7 and the stop bit
//   PARITY_ODD   - 0 even parity, 1 odd parity (only used with PARITY_EN=1)
//
// Ports:
//   in_Clk   - system clock
//   in_Reset - asynchronous active-high reset
//   rx_if    - uart_rx_frame_if.master: serial input and frame results
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 2,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic             in_Clk,
  input  logic             in_Reset,
  uart_rx_frame_if.master  rx_if
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_C = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
  localparam logic          ODD_C  = (PARITY_ODD != 0);
  localparam logic          PEN_C  = (PARITY_EN != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic [1:0]    sync_q;
  logic          rx_s;
  logic [2:0]    state_q;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_byte;
  logic          par_err_q;
  logic          rx_dv_q;
  logic [7:0]    rx_byte_q;
  logic          frame_err_q;
  logic          parity_err_q;

  // Both flops reset high so a reset never fabricates a falling edge.
  always_ff @(posedge in_Clk or posedge in_Reset) begin
    if (in_Reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_if.in_RX_Serial};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge in_Clk or posedge in_Reset) begin
    if (in_Reset) begin
      state_q      <= S_IDLE;
      clk_cnt      <= '0;
      bit_idx      <= 3'd0;
      shift_byte   <= 8'h00;
      par_err_q    <= 1'b0;
      rx_dv_q      <= 1'b0;
      rx_byte_q    <= 8'h00;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rx_dv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= 3'd0;
          if (!rx_s) begin
            state_q <= S_START;
          end
        end

        // Re-check the line at mid start bit; a high here means the low was a glitch.
        S_START: begin
          if (clk_cnt == HALF_C) begin
            clk_cnt <= '0;
            state_q <= rx_s ? S_IDLE : S_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        // From the mid start bit, every full bit period lands at mid data bit.
        S_DATA: begin
          if (clk_cnt == LAST_C) begin
            clk_cnt             <= '0;
            shift_byte[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              state_q <= PEN_C ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (clk_cnt == LAST_C) begin
            clk_cnt   <= '0;
            par_err_q <= ((^shift_byte) ^ rx_s) != ODD_C;
            state_q   <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        // Deliver the frame even on errors; a low stop bit parks in BREAK so a
        // line held low cannot start a second frame.
        S_STOP: begin
          if (clk_cnt == LAST_C) begin
            clk_cnt      <= '0;
            rx_dv_q      <= 1'b1;
            rx_byte_q    <= shift_byte;
            frame_err_q  <= ~rx_s;
            parity_err_q <= par_err_q;
            state_q      <= rx_s ? S_IDLE : S_BREAK;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_BREAK: begin
          clk_cnt <= '0;
          if (rx_s) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_if.out_RX_DV      = rx_dv_q;
  assign rx_if.out_RX_Byte    = rx_byte_q;
  assign rx_if.out_Frame_Err  = frame_err_q;
  assign rx_if.out_Parity_Err = parity_err_q;
  assign rx_if.out_RX_Busy    = (state_q != S_IDLE);

endmodule
